// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and the
// default bit period used by both the receiver and the transmitter.
package uart_pkg;

  localparam int UART_DATA_W       = 8;
  localparam int UART_CLKS_PER_BIT = 868;  // 100 MHz / 115200 baud

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO, first-word-fall-through. The head entry is shown
// combinationally from storage (0 when empty). A push into a full FIFO is
// accepted only if a pop happens in the same cycle; otherwise it is dropped
// and o_overflow pulses. A pop when empty is ignored.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [UART_DATA_W-1:0]     i_data,
  input  logic                       i_pop,
  output logic [UART_DATA_W-1:0]     o_data,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [UART_DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [AW:0]            r_count;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_push;

  assign o_empty    = (r_count == '0);
  assign w_full     = (r_count == (AW+1)'(DEPTH));
  assign w_pop      = i_pop && !o_empty;
  assign w_push     = i_push && (!w_full || w_pop);
  assign o_overflow = i_push && w_full && !w_pop;
  assign o_data     = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_level    = r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; contents need no reset because the head is masked when empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchronizer, bit counter, receive FSM and FIFO.
// Frame is 8N1; defining UART_RX_PARITY_EN makes it 8E1 and enables
// parity_err. Handshake: a byte leaves the FIFO on any clk edge where
// rx_valid && rx_ready; rx_data is only meaningful while rx_valid.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_i,
  output logic [UART_DATA_W-1:0]        rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic                          frame_err,
  output logic                          overrun_err,
  output logic                          parity_err,
  input  logic                          err_clr,
  output rx_state_e                     o_dbg_state
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]             r_sync;
  logic                   r_rx_prev;
  logic                   w_rx;
  logic                   w_fall;
  rx_state_e              r_state;
  rx_state_e              w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [2:0]             r_idx;
  logic [UART_DATA_W-1:0] r_shift;
  logic                   r_push;
  logic                   r_frame_err;
  logic                   r_overrun_err;
  logic                   w_tick;
  logic                   w_cnt_load;
  logic                   w_cnt_half;
  logic                   w_shift_en;
  logic                   w_idx_clr;
  logic                   w_push_set;
  logic                   w_frame_set;
  logic                   w_fifo_empty;
  logic                   w_fifo_ovf;
`ifdef UART_RX_PARITY_EN
  logic                   r_par_bad;
  logic                   r_parity_err;
  logic                   w_par_sample;
  logic                   w_par_set;
`endif

  assign w_rx   = r_sync[1];
  assign w_fall = r_rx_prev && !w_rx;
  assign w_tick = (r_cnt == '0);

  // Synchronizer and edge history reset high so a line held low at reset
  // release is not mistaken for a start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync    <= 2'b11;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync    <= {r_sync[0], rx_i};
      r_rx_prev <= r_sync[1];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state and per-sample control strobes.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_load   = 1'b0;
    w_cnt_half   = 1'b0;
    w_shift_en   = 1'b0;
    w_idx_clr    = 1'b0;
    w_push_set   = 1'b0;
    w_frame_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_sample = 1'b0;
    w_par_set    = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_fall) begin
          w_cnt_load  = 1'b1;
          w_cnt_half  = 1'b1;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (w_tick) begin
          if (!w_rx) begin
            w_cnt_load  = 1'b1;
            w_idx_clr   = 1'b1;
            w_state_nxt = ST_DATA;
          end else begin
            w_state_nxt = ST_IDLE;  // glitch shorter than half a bit
          end
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          w_shift_en = 1'b1;
          w_cnt_load = 1'b1;
          if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = ST_PARITY;
`else
            w_state_nxt = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (w_tick) begin
          w_par_sample = 1'b1;
          w_cnt_load   = 1'b1;
          w_state_nxt  = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (w_tick) begin
          if (w_rx) begin
`ifdef UART_RX_PARITY_EN
            if (r_par_bad) w_par_set = 1'b1;
            else
`endif
            w_push_set  = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_frame_set = 1'b1;
            w_state_nxt = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (w_rx) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Bit-period counter, bit index, shift register and delayed push strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_push  <= 1'b0;
    end else begin
      if (w_cnt_load)   r_cnt <= w_cnt_half ? CNT_HALF : CNT_FULL;
      else if (!w_tick) r_cnt <= r_cnt - CNT_W'(1);
      if (w_idx_clr)       r_idx <= '0;
      else if (w_shift_en) r_idx <= r_idx + 3'd1;
      if (w_shift_en) r_shift <= {w_rx, r_shift[UART_DATA_W-1:1]};
      r_push <= w_push_set;
    end
  end

  // Sticky error flags; a new error wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame_err   <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      if (w_frame_set)  r_frame_err <= 1'b1;
      else if (err_clr) r_frame_err <= 1'b0;
      if (w_fifo_ovf)   r_overrun_err <= 1'b1;
      else if (err_clr) r_overrun_err <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Even parity check: the received parity bit must equal the XOR of the data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (w_par_sample) r_par_bad <= w_rx ^ (^r_shift);
      if (w_par_set)    r_parity_err <= 1'b1;
      else if (err_clr) r_parity_err <= 1'b0;
    end
  end
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (r_push),
    .i_data     (r_shift),
    .i_pop      (rx_ready),
    .o_data     (rx_data),
    .o_empty    (w_fifo_empty),
    .o_level    (rx_level),
    .o_overflow (w_fifo_ovf)
  );

  assign rx_valid    = !w_fifo_empty;
  assign frame_err   = r_frame_err;
  assign overrun_err = r_overrun_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core. Runs at a short bit period to keep the run small.
// The model schedules frame outcomes from the documented latency, keeps an
// expected FIFO queue and flags, and is compared with the DUT every cycle.
module tb_uart_rx_core;
  import uart_pkg::*;

  localparam int CPB   = 16;
  localparam int DEPTH = 8;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN    = 1'b1;
  localparam int PAR_EXTRA = CPB;
`else
  localparam bit PAR_EN    = 1'b0;
  localparam int PAR_EXTRA = 0;
`endif
  localparam int EV_PUSH  = 0;
  localparam int EV_FRAME = 1;
  localparam int EV_PAR   = 2;

  typedef struct {
    int unsigned cyc;
    int          kind;
    logic [7:0]  data;
  } ev_t;

  logic       clk;
  logic       rst_n;
  logic       rx_i;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [3:0] rx_level;
  logic       frame_err;
  logic       overrun_err;
  logic       parity_err;
  logic       err_clr;
  rx_state_e  dbg_state;

  uart_rx_core #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_i        (rx_i),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_level    (rx_level),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err),
    .err_clr     (err_clr),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model state / scoreboard ----------------
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;
  bit          chk_en = 1'b0;
  logic [7:0]  exp_q[$];
  ev_t         ev_q[$];
  bit          m_fe = 1'b0;
  bit          m_oe = 1'b0;
  bit          m_pe = 1'b0;
  int unsigned last_n0 = 0;
  int          rise_cnt = 0;
  int unsigned rise_cyc = 0;
  logic [7:0]  rise_data = 8'h00;
  bit          mon_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  // Model: advance on every active edge using the values the DUT also sees.
  initial forever begin
    bit         do_pop;
    bit         was_full;
    bit         push;
    logic [7:0] push_d;
    ev_t        ev;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      ev_q.delete();
      m_fe = 1'b0;
      m_oe = 1'b0;
      m_pe = 1'b0;
    end else begin
      do_pop   = rx_ready && (exp_q.size() > 0);
      was_full = (exp_q.size() == DEPTH);
      push     = 1'b0;
      push_d   = 8'h00;
      if (err_clr) begin
        m_fe = 1'b0;
        m_oe = 1'b0;
        m_pe = 1'b0;
      end
      while (ev_q.size() > 0 && ev_q[0].cyc <= cyc) begin
        ev = ev_q.pop_front();
        if (ev.cyc == cyc) begin
          if (ev.kind == EV_PUSH) begin
            push   = 1'b1;
            push_d = ev.data;
          end else if (ev.kind == EV_FRAME) begin
            m_fe = 1'b1;
          end else begin
            m_pe = 1'b1;
          end
        end
      end
      if (do_pop) void'(exp_q.pop_front());
      if (push) begin
        if (was_full && !do_pop) m_oe = 1'b1;
        else                     exp_q.push_back(push_d);
      end
    end
  end

  // Compare process: DUT outputs against the model, once per cycle.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("rx_valid", 32'(rx_valid), 32'(exp_q.size() != 0));
      chk("rx_level", 32'(rx_level), 32'(exp_q.size()));
      if (exp_q.size() != 0) chk("rx_data", 32'(rx_data), 32'(exp_q[0]));
      chk("frame_err", 32'(frame_err), 32'(m_fe));
      chk("overrun_err", 32'(overrun_err), 32'(m_oe));
      chk("parity_err", 32'(parity_err), 32'(m_pe));
    end
  end

  // Monitor rising edges of rx_valid for latency checks.
  initial forever begin
    @(negedge clk);
    if (rx_valid === 1'b1 && !mon_prev) begin
      rise_cnt++;
      rise_cyc  = cyc;
      rise_data = rx_data;
    end
    mon_prev = (rx_valid === 1'b1);
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic drive_bit(input logic b);
    rx_i = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    rx_i = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par);
    int unsigned n0;
    int unsigned s_edge;
    ev_t         ev;
    n0     = cyc + 1;  // first edge that samples the start bit
    s_edge = n0 + 2 + 9 * CPB + CPB / 2 + PAR_EXTRA;
    if (bad_par && PAR_EN) ev = '{s_edge, EV_PAR, d};
    else                   ev = '{s_edge + 1, EV_PUSH, d};
    ev_q.push_back(ev);
    last_n0 = n0;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ bad_par);
`endif
    drive_bit(1'b1);
  endtask

  task automatic send_break(input int nbits);
    int unsigned n0;
    ev_t         ev;
    n0 = cyc + 1;
    ev = '{n0 + 2 + 9 * CPB + CPB / 2 + PAR_EXTRA, EV_FRAME, 8'h00};
    ev_q.push_back(ev);
    rx_i = 1'b0;
    repeat (nbits * CPB) @(negedge clk);
    chk("break_state", 32'(dbg_state), 32'(ST_BREAK));
    rx_i = 1'b1;
  endtask

  task automatic pop_expect(input logic [7:0] exp);
    chk("pop_valid", 32'(rx_valid), 32'd1);
    chk("pop_data", 32'(rx_data), 32'(exp));
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int r0;
    logic [7:0] b2b [3];
    b2b[0] = 8'h00;
    b2b[1] = 8'hFF;
    b2b[2] = 8'hA5;
    rx_i     = 1'b1;
    rx_ready = 1'b0;
    err_clr  = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);

    // reset values
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_level", 32'(rx_level), 32'd0);
    chk("rst_data", 32'(rx_data), 32'd0);
    chk("rst_flags", 32'({frame_err, overrun_err, parity_err}), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk_en = 1'b1;
    rst_n  = 1'b1;
    idle_bits(2);

    // single byte with consumer always ready: one valid pulse, fixed latency
    rx_ready = 1'b1;
    r0 = rise_cnt;
    send_frame(8'h55, 1'b0);
    idle_bits(2);
    chk("single_pulses", 32'(rise_cnt - r0), 32'd1);
    chk("single_data", 32'(rise_data), 32'h55);
    chk("single_latency", rise_cyc - last_n0, 32'(155 + PAR_EXTRA));
    rx_ready = 1'b0;

    // back-to-back frames, no idle gap
    for (int i = 0; i < 3; i++) send_frame(b2b[i], 1'b0);
    idle_bits(1);
    chk("b2b_level", 32'(rx_level), 32'd3);
    pop_expect(8'h00);
    pop_expect(8'hFF);
    pop_expect(8'hA5);

    // overrun: ninth byte dropped
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0);
    idle_bits(1);
    chk("ovr_level", 32'(rx_level), 32'd8);
    chk("ovr_flag", 32'(overrun_err), 32'd1);
    for (int i = 1; i <= 8; i++) pop_expect(8'(i));
    chk("ovr_empty", 32'(rx_valid), 32'd0);
    pulse_clr();
    chk("ovr_clr", 32'(overrun_err), 32'd0);

    // break: one framing error, then normal reception
    send_break(20);
    idle_bits(2);
    chk("brk_flag", 32'(frame_err), 32'd1);
    chk("brk_level", 32'(rx_level), 32'd0);
    send_frame(8'h3C, 1'b0);
    idle_bits(1);
    chk("brk_next_data", 32'(rx_data), 32'h3C);
    pulse_clr();
    chk("brk_clr", 32'(frame_err), 32'd0);

    // glitch shorter than half a bit: nothing happens
    rx_i = 1'b0;
    repeat (4) @(negedge clk);
    idle_bits(2);
    chk("glitch_level", 32'(rx_level), 32'd1);
    chk("glitch_flags", 32'({frame_err, overrun_err, parity_err}), 32'd0);
    chk("glitch_state", 32'(dbg_state), 32'(ST_IDLE));

    // reset in the middle of bit 4 of 0x81; FIFO still holds 0x3C
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    rx_i = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    rx_i  = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("mrst_level", 32'(rx_level), 32'd0);
    chk("mrst_state", 32'(dbg_state), 32'(ST_IDLE));
    idle_bits(2);
    send_frame(8'h81, 1'b0);
    idle_bits(1);
    pop_expect(8'h81);

`ifdef UART_RX_PARITY_EN
    // parity: good frame accepted, bad frame discarded with flag
    send_frame(8'h07, 1'b0);
    idle_bits(1);
    pop_expect(8'h07);
    send_frame(8'h07, 1'b1);
    idle_bits(1);
    chk("par_flag", 32'(parity_err), 32'd1);
    chk("par_level", 32'(rx_level), 32'd0);
`endif

    idle_bits(2);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Synthesizable UART receiver for the secure SoC. It deserializes the `uart_rx` pin, which is currently tied idle at the top level. Frames are 8N1 by default, or 8E1 when parity is compiled in. Received bytes are buffered in a small FIFO and presented on a valid/ready stream to the UART peripheral's bus register block, mirroring the existing transmit path.

## Interface
- `CLKS_PER_BIT`, default 868: clk cycles per bit (100 MHz / 115200); must be ≥ 16.
- `FIFO_DEPTH`, default 8: receive FIFO entries; power of two, ≥ 2.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `rx_i`  in  1  asynchronous serial line, idle high.
- `rx_data`  out  8  FIFO head byte; valid only while `rx_valid`.
- `rx_valid`  out  1  FIFO non-empty.
- `rx_ready`  in  1  consumer pop; the pop happens when `rx_valid && rx_ready`.
- `rx_level`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- `frame_err`  out  1  sticky: a stop bit was sampled low.
- `overrun_err`  out  1  sticky: a byte was dropped because the FIFO was full.
- `parity_err`  out  1  sticky: parity mismatch; tied 0 without `UART_RX_PARITY_EN`.
- `err_clr`  in  1  clears all sticky error flags; a new error in the same cycle wins.

## Operation
- `rx_i` passes through a 2-flop synchronizer. Both flops reset to 1, so a line that is low at reset release is not taken as a start bit.
- State machine: IDLE, START, DATA, PARITY, STOP, BREAK. One bit counter (CLKS_PER_BIT-wide) and one 3-bit index.
- **IDLE:** a synchronized 1→0 transition loads the counter and enters START.
- **START:** after CLKS_PER_BIT/2 cycles, resample the line.
  - Low: go to DATA.
  - High: glitch; return to IDLE with no flag.
- **DATA:** sample every CLKS_PER_BIT cycles, 8 bits, LSB first, shifted into a register.
- **PARITY** (only with the macro): one sample; compare against even parity.
- **STOP:** one sample.
  - High: push the byte, unless a parity error was detected, in which case discard it and set `parity_err`. Then go to IDLE.
  - Low: discard the byte, set `frame_err`, go to BREAK.
- **BREAK:** wait for the synchronized line to be high, then go to IDLE. This means a break produces exactly one `frame_err` event.
- **FIFO:**
  - A push when full with no simultaneous pop drops the byte and sets `overrun_err`; the FIFO contents are unchanged.
  - Push and pop in the same cycle when full: both take effect and the level is unchanged.
  - Pop when empty is ignored.
- `rx_data` is first-word-fall-through: it shows the head entry combinationally from the registered storage.

## Timing
- Reset values: `rx_valid`=0, `rx_level`=0, `rx_data`=0, all error flags 0, state IDLE.
- Reset mid-frame aborts the frame and empties the FIFO.
- Latency: `rx_valid` rises 2 + (9×CLKS_PER_BIT + CLKS_PER_BIT/2) + 1 cycles after the first clk edge that samples `rx_i` low.
  - That is 8249 cycles at the default CLKS_PER_BIT.
  - Add CLKS_PER_BIT when parity is enabled.
- A new start bit is accepted the cycle after the STOP sample, so back-to-back frames need no idle gap.
- Error flags set the cycle after the offending sample. `err_clr` takes effect on the next edge.
- After a pop, `rx_level` and `rx_valid` update on the next edge.

## Configuration
- `UART_RX_PARITY_EN` defined: the frame is 8E1, the PARITY state exists, and `parity_err` is live.
- `UART_RX_PARITY_EN` undefined: the frame is 8N1, the PARITY state and its logic are absent, and `parity_err` is constant 0.

## Structure
- Shared package `uart_pkg`:
  - state encoding enum;
  - `UART_DATA_W`=8;
  - default `CLKS_PER_BIT` constant, shared with the transmitter.
- Sub-module `uart_rx_fifo` (parameterized depth, FWFT, level output) holds the FIFO.
- The top level keeps the synchronizer, counters and FSM.

## Test plan
- **Single byte:** drive 0x55 at 8680 ns/bit with `rx_ready`=1 → `rx_valid` pulses once with `rx_data`=0x55; no error flags.
- **Back-to-back:** send 0x00, 0xFF, 0xA5 with no gaps and hold `rx_ready`=0 → `rx_level`=3; popping three times yields 0x00, 0xFF, 0xA5 in order.
- **Overrun:** send 9 bytes (0x01..0x09) with `rx_ready`=0 → `rx_level`=8 and `overrun_err`=1; pops return 0x01..0x08 and 0x09 is lost. Then pulse `err_clr` → `overrun_err`=0.
- **Framing/break:** hold `rx_i` low for 20 bit times → `frame_err`=1, no push, FSM stays in BREAK. After the line returns high, a following 0x3C is received correctly.
- **Glitch and reset:**
  - A 200-cycle low pulse gives no push and no flags.
  - Asserting `rst_n`=0 during bit 4 of a frame gives `rx_level`=0 and IDLE; the next full frame 0x81 is received correctly.
- **Parity** (macro defined): send 0x07 with the correct parity bit 1 → received. Send 0x07 with parity bit 0 → `parity_err`=1 and no push.
